// File: rtl/looper_tester_pkg.sv
// looper_tester_pkg: shared FSM encodings, start command and baud divisors for the looper board tester
package looper_tester_pkg;
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    CLR_MEM    = 4'd1,
    LOAD_PC    = 4'd2,
    RUN        = 4'd3,
    FLUSH      = 4'd4,
    FIN        = 4'd5,
    TRANS_LOAD = 4'd6,
    TRANS_WAIT = 4'd7,
    TRANS_SEND = 4'd8,
    DONE       = 4'd9
  } state_e;
  localparam logic [7:0] CMD_START = 8'h73;
  localparam logic [10:0] DIV_4800  = 11'd1302;
  localparam logic [10:0] DIV_9600  = 11'd651;
  localparam logic [10:0] DIV_19200 = 11'd326;
  localparam logic [10:0] DIV_38400 = 11'd163;
  function automatic logic [10:0] baud_div(input logic [1:0] cfg);
    return cfg == 2'b00 ? DIV_4800 : cfg == 2'b01 ? DIV_9600 : cfg == 2'b10 ? DIV_19200 : DIV_38400;
  endfunction
endpackage

// File: rtl/looper_board_tester_spart.sv
// spart: 8N1 UART receiver and transmitter sharing one 16x oversampling baud tick generator
module spart
  import looper_tester_pkg::*;
#(
  parameter int unsigned TICK_DIV = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rxd,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  logic [10:0] div_w, bcnt_q;
  logic        tick;
  logic [1:0]  rx_sync_q;
  logic        rx_busy_q, rx_valid_q;
  logic [3:0]  rx_tick_q, rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        tx_busy_q;
  logic [9:0]  tx_sh_q;
  logic [3:0]  tx_tick_q, tx_cnt_q;
  logic        rxs;
  // a nonzero TICK_DIV replaces the br_cfg divisor table
  always_comb div_w = TICK_DIV != 0 ? 11'(TICK_DIV) : baud_div(br_cfg);
  assign tick     = bcnt_q >= div_w - 11'd1;
  assign rxs      = rx_sync_q[1];
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_sh_q;
  assign tx_busy  = tx_busy_q;
  assign txd      = tx_busy_q ? tx_sh_q[0] : 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) bcnt_q <= '0;
    else bcnt_q <= tick ? '0 : bcnt_q + 11'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rxd};
      rx_valid_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rxs) {rx_busy_q, rx_tick_q, rx_bit_q} <= {1'b1, 4'd0, 4'd0};
      end else if (tick) begin
        rx_tick_q <= rx_tick_q + 4'd1;
        // bit 0 is the start bit (checked at mid-bit), 1..8 data, 9 stop
        if (rx_bit_q == 4'd0 && rx_tick_q == 4'd7) begin
          if (rxs) rx_busy_q <= 1'b0;
          else {rx_tick_q, rx_bit_q} <= {4'd0, 4'd1};
        end else if (rx_bit_q != 4'd0 && rx_tick_q == 4'd15) begin
          rx_tick_q <= '0;
          rx_bit_q  <= rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd9) begin
            rx_busy_q  <= 1'b0;
            rx_valid_q <= rxs;
          end else rx_sh_q <= {rxs, rx_sh_q[7:1]};
        end
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_tick_q <= '0;
      tx_cnt_q  <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start) {tx_busy_q, tx_sh_q, tx_tick_q, tx_cnt_q} <= {1'b1, 1'b1, tx_data, 1'b0, 4'd0, 4'd0};
    end else if (tick) begin
      tx_tick_q <= tx_tick_q + 4'd1;
      if (tx_tick_q == 4'd15) begin
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        tx_cnt_q <= tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd9) tx_busy_q <= 1'b0;
      end
    end
endmodule

// File: rtl/looper_board_tester.sv
// looper_board_tester: serial-started looper benchmark run that reports its 32-bit cycle count over UART
module looper_board_tester
  import looper_tester_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 16,
  parameter int unsigned BENCH_LEN  = 64,
  parameter int unsigned TICK_DIV   = 0
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        rxd,
  input  logic [1:0]  br_cfg,
  output logic        txd,
  output logic [3:0]  state,
  output logic [11:0] d,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        dvi_clk,
  output logic        dvi_clk_n,
  output logic        dvi_rst,
  output logic        GPIO_LED_1,
  inout  wire         scl_tri,
  inout  wire         sda_tri
);
  state_e      state_q, state_d;
  logic [7:0]  cmd;
  logic [7:0]  stored_spart_data [8];
  logic [63:0] wrt_mem_data;
  logic [63:0] cpu_pc;
  logic [31:0] cyc_q, cnt_q, tx_buf_q;
  logic        cap_q;
  logic [2:0]  cap_idx_q;
  logic [1:0]  byte_idx_q;
  logic        flsh, mem_sys_fin, start, tx_start, tx_busy, rx_valid;
  logic [7:0]  rx_data;
  spart #(.TICK_DIV(TICK_DIV)) u_spart (
    .clk(clk_100mhz), .rst(rst), .br_cfg(br_cfg), .rxd(rxd),
    .tx_start(tx_start), .tx_data(tx_buf_q[31:24]), .txd(txd), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );
  assign d           = '0;
  assign blank       = 1'b1;
  assign hsync       = 1'b0;
  assign vsync       = 1'b0;
  assign dvi_clk     = clk_100mhz;
  assign dvi_clk_n   = ~clk_100mhz;
  assign dvi_rst     = rst;
  assign scl_tri     = 1'bz;
  assign sda_tri     = 1'bz;
  assign state       = state_q;
  assign GPIO_LED_1  = state_q == RUN || state_q == FLUSH;
  assign flsh        = state_q == FLUSH;
  assign mem_sys_fin = state_q >= FIN && state_q <= TRANS_SEND;
  always_comb wrt_mem_data = {stored_spart_data[0], stored_spart_data[1], stored_spart_data[2], stored_spart_data[3],
                              stored_spart_data[4], stored_spart_data[5], stored_spart_data[6], stored_spart_data[7]};
  // cap_q stays low unless an address is still being collected, so a directly written cmd starts at once
  assign start = state_q == IDLE && cmd == CMD_START && !cap_q;
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    case (state_q)
      IDLE:       state_d = start ? CLR_MEM : IDLE;
      CLR_MEM:    state_d = cnt_q == 32'(CLR_CYCLES - 1) ? LOAD_PC : CLR_MEM;
      LOAD_PC:    state_d = RUN;
      RUN:        state_d = cnt_q == 32'(BENCH_LEN - 1) ? FLUSH : RUN;
      FLUSH:      state_d = flsh ? FIN : FLUSH;
      FIN:        state_d = TRANS_LOAD;
      TRANS_LOAD: state_d = TRANS_WAIT;
      TRANS_WAIT: state_d = !tx_busy && mem_sys_fin ? TRANS_SEND : TRANS_WAIT;
      TRANS_SEND: begin
        tx_start = 1'b1;
        state_d  = byte_idx_q == 2'd3 ? DONE : TRANS_WAIT;
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_100mhz or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      cmd        <= '0;
      for (int i = 0; i < 8; i++) stored_spart_data[i] <= '0;
      cap_q      <= 1'b0;
      cap_idx_q  <= '0;
      cpu_pc     <= '0;
      cyc_q      <= '0;
      cnt_q      <= '0;
      tx_buf_q   <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_d != state_q ? '0 : cnt_q + 32'd1;
      if (start) cmd <= '0;
      else if (rx_valid && state_q == IDLE) begin
        if (rx_data == CMD_START) begin
          cmd       <= CMD_START;
          cap_q     <= 1'b1;
          cap_idx_q <= '0;
        end else if (cap_q) begin
          stored_spart_data[cap_idx_q] <= rx_data;
          cap_idx_q <= cap_idx_q + 3'd1;
          if (cap_idx_q == 3'd7) cap_q <= 1'b0;
        end
      end
      cpu_pc <= state_q == CLR_MEM ? '0 : state_q == LOAD_PC ? wrt_mem_data : state_q == RUN ? cpu_pc + 64'd1 : cpu_pc;
      cyc_q  <= state_q == CLR_MEM ? '0 : state_q == RUN ? cyc_q + 32'(cyc_q != '1) : cyc_q;
      if (state_q == TRANS_LOAD) begin
        tx_buf_q   <= cyc_q;
        byte_idx_q <= '0;
      end else if (state_q == TRANS_SEND) begin
        tx_buf_q   <= tx_buf_q << 8;
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
endmodule

// File: tb/tb_looper_board_tester.sv
// tb_looper_board_tester: table, sequence and randomized checks of the looper board tester
module tb_looper_board_tester;
  timeunit 1ns;
  timeprecision 1ps;
  localparam int CLR = 16, BLEN = 64, DIV = 2, BIT = 16 * DIV;
  localparam int LAT = 1 + CLR + 1 + BLEN + 4;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [1:0] br_cfg = 2'b11;
  logic txd, blank, hsync, vsync, dvi_clk, dvi_clk_n, dvi_rst, led;
  logic [3:0] state;
  logic [11:0] d;
  wire scl_tri, sda_tri;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  looper_board_tester #(.CLR_CYCLES(CLR), .BENCH_LEN(BLEN), .TICK_DIV(DIV)) dut (
    .clk_100mhz(clk), .rst(rst), .rxd(rxd), .br_cfg(br_cfg), .txd(txd), .state(state),
    .d(d), .blank(blank), .hsync(hsync), .vsync(vsync), .dvi_clk(dvi_clk), .dvi_clk_n(dvi_clk_n),
    .dvi_rst(dvi_rst), .GPIO_LED_1(led), .scl_tri(scl_tri), .sda_tri(sda_tri)
  );
  typedef struct {
    logic [7:0]  first;
    logic [63:0] addr;
    bit          go;
  } vec_t;
  vec_t vecs[4];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (BIT) @(posedge clk);
    end
  endtask
  task automatic send_addr(input logic [63:0] a);
    for (int i = 0; i < 8; i++) send_byte(a[63 - 8 * i -: 8]);
  endtask
  task automatic recv_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'hEE;
    while (txd !== 1'b0 && n < 20 * BIT) begin
      @(negedge clk);
      n++;
    end
    if (txd !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL tx_timeout: no start bit within %0d cycles", n);
      return;
    end
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = txd;
    end
    repeat (BIT) @(negedge clk);
  endtask
  task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, state, s);
  endtask
  task automatic hier_start(input logic [63:0] a);
    @(negedge clk);
    for (int i = 0; i < 8; i++) dut.stored_spart_data[i] = a[63 - 8 * i -: 8];
    dut.cmd = 8'h73;
  endtask
  // model: the count is the number of RUN cycles clipped to 32 bits, sent MSB first
  task automatic check_tx(input string nm);
    logic [7:0] b;
    logic [31:0] cnt;
    cnt = BLEN > 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'(BLEN);
    for (int k = 0; k < 4; k++) begin
      recv_byte(b);
      chk({nm, "_tx"}, b, 8'(cnt >> (24 - 8 * k)));
    end
  endtask
  task automatic check_run(input logic [63:0] a, input string nm);
    wait_state(4'd3, 4000, {nm, "_reach_run"});
    chk({nm, "_pc_start"}, dut.cpu_pc, a);
    chk({nm, "_wrt"}, dut.wrt_mem_data, a);
    wait_state(4'd4, 500, {nm, "_reach_flush"});
    chk({nm, "_pc_end"}, dut.cpu_pc, a + 64'(BLEN));
    chk({nm, "_led"}, led, 1'b1);
    check_tx(nm);
    wait_state(4'd0, 4000, {nm, "_idle"});
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit seen;
    logic [63:0] a;
    logic [7:0] b, g;
    vecs[0] = '{8'h73, 64'h0000_0000_0000_0010, 1'b1};
    vecs[1] = '{8'h41, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[2] = '{8'h73, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1};
    vecs[3] = '{8'h00, 64'h0000_0000_0000_0005, 1'b0};
    #7 rst = 1'b0;
    #1;
    chk("rst_state", state, 4'd0);
    chk("rst_txd", txd, 1'b1);
    chk("rst_blank", blank, 1'b1);
    chk("rst_led", led, 1'b0);
    chk("rst_d", {d, hsync, vsync, dvi_rst}, 15'd0);
    chk("rst_pc", dut.cpu_pc, 64'd0);
    chk("rst_cmd", dut.cmd, 8'd0);
    chk("rst_wrt", dut.wrt_mem_data, 64'd0);
    chk("dvi_clk", {dvi_clk, dvi_clk_n}, {clk, ~clk});
    hier_start(64'h4);
    #1;
    chk("hier_wrt", dut.wrt_mem_data, 64'h4);
    chk("hier_cmd", dut.cmd, 8'h73);
    n = 0;
    seen = 0;
    while (state !== 4'd8 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk("hier_state1", state, 4'd1);
        chk("hier_cmd_clr", dut.cmd, 8'd0);
      end
      if (state == 4'd3 && !seen) begin
        seen = 1;
        chk("hier_pc_run", dut.cpu_pc, 64'h4);
      end
    end
    chk("hier_latency", 64'(n), 64'(LAT));
    check_tx("hier");
    wait_state(4'd0, 4000, "hier_idle");
    foreach (vecs[i]) begin
      send_byte(vecs[i].first);
      send_addr(vecs[i].addr);
      if (vecs[i].go) check_run(vecs[i].addr, $sformatf("vec%0d", i));
      else begin
        repeat (200) @(negedge clk);
        chk($sformatf("vec%0d_ignored", i), state, 4'd0);
        chk($sformatf("vec%0d_cmd", i), dut.cmd, 8'd0);
      end
    end
    send_byte(8'h73);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'h73);
    send_addr(64'h1122_3344_5566_7788);
    check_run(64'h1122_3344_5566_7788, "restart");
    for (int r = 0; r < 3; r++) begin
      a = {$urandom, $urandom};
      hier_start(a);
      check_run(a, "rnd_hier");
    end
    for (int r = 0; r < 2; r++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'h73) g = 8'h72;
      send_byte(g);
      send_byte(8'h73);
      for (int i = 0; i < 8; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h73) b = 8'h74;
        a[63 - 8 * i -: 8] = b;
        send_byte(b);
      end
      check_run(a, "rnd_serial");
    end
    hier_start(64'h5);
    wait_state(4'd3, 200, "mid_run_reach");
    #2 rst = 1'b1;
    #1;
    chk("mid_run_state", state, 4'd0);
    chk("mid_run_txd", txd, 1'b1);
    chk("mid_run_pc", dut.cpu_pc, 64'd0);
    #5 rst = 1'b0;
    hier_start(64'h9);
    wait_state(4'd8, 300, "mid_tx_reach");
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_tx_started", txd, 1'b0);
    repeat (BIT + 3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_tx_txd", txd, 1'b1);
    chk("mid_tx_state", state, 4'd0);
    #5 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {state, txd}, {4'd0, 1'b1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/looper_board_tester.md
# looper_board_tester

Board-level benchmark harness for the looper processor. It receives a start command and a 64-bit benchmark start address over a SPART/UART serial link and runs a simplified looper execution engine from that address. It then counts execution cycles and transmits the 32-bit cycle count back over the serial line. The display (DVI) and I2C pins are held in safe idle levels so the block drops straight into the board top level.

## Interface
- CLR_CYCLES, 16: number of cycles spent in CLR_MEM.
- BENCH_LEN, 64: number of instructions the engine retires before finishing.
- clk_100mhz  in  1  board clock, 100 MHz; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  UART receive, 8N1, idle high.
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- txd  out  1  UART transmit, 8N1, idle high.
- state  out  4  current FSM state encoding.
- d  out  12  DVI data, constant 0.
- blank  out  1  constant 1.
- hsync, vsync  out  1 each  constant 0.
- dvi_clk  out  1  equals clk_100mhz.
- dvi_clk_n  out  1  equals ~clk_100mhz.
- dvi_rst  out  1  equals rst.
- GPIO_LED_1  out  1  high while in RUN or FLUSH.
- scl_tri, sda_tri  inout  1 each  always released (high-Z).

## Operation
- Receiver path:
  - Baud tick divisor = 100e6/(16·baud): 1302, 651, 326, 163.
  - Start bit is sampled at mid-bit (8 ticks); 8 data bits are taken LSB first.
- Command byte handling, valid only in IDLE:
  - 0x73 ('s') is latched into the register `cmd`, and the next 8 received bytes fill `stored_spart_data[0..7]`.
  - Other command bytes are discarded.
- `wrt_mem_data[63:0]` = {stored_spart_data[0] … stored_spart_data[7]}; byte 7 is the LSB.
- Start condition: in IDLE, `cmd==8'h73` and all 8 address bytes are present.
  - `cmd`, `stored_spart_data` and `wrt_mem_data` are internal registers.
  - A hierarchical write to `cmd` with the data bytes already set must also start a run on the next edge.
- FSM encodings and transitions:
  - 0 IDLE: outputs quiescent; moves to CLR_MEM on start and clears `cmd`.
  - 1 CLR_MEM: stays for CLR_CYCLES cycles; zeroes the cycle counter and `cpu_pc`.
  - 2 LOAD_PC: `cpu_pc` ← wrt_mem_data.
  - 3 RUN: each cycle `cpu_pc`+=1 and cycle count +=1; after BENCH_LEN increments moves to FLUSH.
  - 4 FLUSH: `flsh`=1 for one cycle.
  - 5 FIN: `mem_sys_fin`=1, held through TRANS_SEND.
  - 6 TRANS_LOAD: loads 4 count bytes, MSB first.
  - 7 TRANS_WAIT: waits for the transmitter to be idle.
  - 8 TRANS_SEND: sends one byte, then returns to TRANS_WAIT; after 4 bytes goes to 9.
  - 9 DONE: one cycle, then IDLE.
- Encodings 10–15 are illegal and return to IDLE.
- Counters:
  - Cycle counter is 32-bit and saturates at 0xFFFFFFFF.
  - `cpu_pc` is 64-bit and wraps modulo 2^64.
- Bytes received outside IDLE are dropped.
- A 0x73 arriving mid-address restarts address capture.

## Timing
- Reset values:
  - txd=1, state=0, GPIO_LED_1=0, `cpu_pc`=0, `flsh`=0, `mem_sys_fin`=0.
  - `cmd`=0, `stored_spart_data` and `wrt_mem_data` all zeros.
- DVI and I2C outputs are combinational constants or passthroughs.
- Reset mid-operation: immediate return to IDLE; any partial transmit frame is aborted with txd=1.
- Start-to-LOAD_PC: 1 + CLR_CYCLES cycles.
- RUN lasts exactly BENCH_LEN cycles, so the transmitted count equals BENCH_LEN.
- State reaches 8 (TRANS_SEND) at 1+CLR_CYCLES+1+BENCH_LEN+4 cycles after the start edge; 86 cycles with defaults.
- Transmitter: 10 bits per byte at 16 ticks per bit; a new byte is accepted only when idle.

## Structure
- Shared package `looper_tester_pkg` holds:
  - the state enum (4-bit encodings above);
  - CMD_START=8'h73;
  - the baud divisor constants.
- A natural sub-module is `spart` (UART rx/tx with a shared baud generator); the FSM, counters and data registers stay in the top module.

## Test plan
- Reset: hold rst 7 ns, release → state=0, txd=1, blank=1, GPIO_LED_1=0.
- Hierarchical start: set stored bytes 0..6=0x00 and byte 7=0x04, then `cmd`=0x73.
  - wrt_mem_data=0x4 and cmd=0x73 are visible immediately.
  - state=1 on the next edge; `cpu_pc`=0x4 in RUN.
  - state=8 after 86 cycles.
- Serial start at br_cfg=11: send 0x73 followed by 00×7, 0x10.
  - Run begins with `cpu_pc`=0x10.
  - txd then emits 0x00,0x00,0x00,0x40.
- Ignored command: send 0x41 then 8 bytes → state stays 0.
- Reset mid-RUN: assert rst during state 3 → state=0, txd=1 and `cpu_pc`=0 immediately.
- Wrap: address 0xFFFFFFFFFFFFFFF0 → `cpu_pc` wraps through 0; the count is still 64.
